// File: rtl/clkdiv_pkg.sv
// Shared constants, configuration request type and divide-value helper
// for the multi-channel clock-enable divider.
package clkdiv_pkg;

  localparam int     DFLT_N_CH  = 4;
  localparam int     DFLT_CNT_W = 32;
  localparam int     CH_W_MAX   = 8;
  localparam longint CLK_HZ     = 100_000_000;

  // D such that a channel toggles at f_hz: period 2*(D+1) clk cycles.
  function automatic logic [DFLT_CNT_W-1:0] div_for_hz(input longint clk_hz, input longint f_hz);
    return DFLT_CNT_W'(clk_hz / (2 * f_hz) - 1);
  endfunction

  // 72 Hz refresh rate at 100 MHz -> 694443
  localparam logic [DFLT_CNT_W-1:0] DFLT_DIV = div_for_hz(CLK_HZ, 72);

  typedef struct packed {
    logic [CH_W_MAX-1:0]   ch;
    logic [DFLT_CNT_W-1:0] div;
    logic                  en;
  } cfg_req_t;

endpackage

// File: rtl/clock_divider_ctrl_if.sv
// Configuration valid/ready port: master drives a request, slave accepts
// it when cfg_ready is high for the addressed channel.
interface clock_divider_ctrl_if #(
  parameter int CH_W  = 2,
  parameter int CNT_W = 32
);
  logic             cfg_valid;
  logic             cfg_ready;
  logic [CH_W-1:0]  cfg_ch;
  logic [CNT_W-1:0] cfg_div;
  logic             cfg_en;

  modport master (output cfg_valid, cfg_ch, cfg_div, cfg_en, input cfg_ready);
  modport slave  (input cfg_valid, cfg_ch, cfg_div, cfg_en, output cfg_ready);
endinterface

// File: rtl/clock_divider_channel.sv
// One divider channel: free-running counter, pending-update registers and
// the park logic that keeps reconfiguration glitch-free.
module clock_divider_channel
  import clkdiv_pkg::*;
#(
  parameter int               CNT_W   = DFLT_CNT_W,
  parameter logic [CNT_W-1:0] DEF_DIV = CNT_W'(DFLT_DIV)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_sync,
  input  logic             i_acc,
  input  logic [CNT_W-1:0] i_div,
  input  logic             i_en,
  output logic             o_out,
  output logic             o_tick,
  output logic             o_busy
);

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_div;
  logic [CNT_W-1:0] r_pend_div;
  logic             r_pend_en;
  logic             r_en;
  logic             r_out;
  logic             r_tick;
  logic             r_busy;
  logic             w_term;

  assign w_term = (r_cnt == r_div);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt      <= '0;
      r_div      <= DEF_DIV;
      r_pend_div <= '0;
      r_pend_en  <= 1'b0;
      r_en       <= 1'b1;
      r_out      <= 1'b0;
      r_tick     <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_tick <= 1'b0;
      if (i_sync) begin
        r_cnt <= '0;
        r_out <= 1'b0;
        if (r_busy) begin
          r_div  <= r_pend_div;
          r_en   <= r_pend_en;
          r_busy <= 1'b0;
        end
      end else if (r_en) begin
        if (w_term) begin
          r_cnt <= '0;
          // Disabling only lands on a falling toggle so the high phase is never cut short.
          if (r_busy && !r_pend_en && r_out) begin
            r_out  <= 1'b0;
            r_en   <= 1'b0;
            r_div  <= r_pend_div;
            r_busy <= 1'b0;
          end else begin
            r_out  <= !r_out;
            r_tick <= !r_out;
            if (r_busy && r_pend_en) begin
              r_div  <= r_pend_div;
              r_busy <= 1'b0;
            end
          end
        end else begin
          r_cnt <= r_cnt + CNT_W'(1);
        end
      end else if (r_busy) begin
        r_div  <= r_pend_div;
        r_en   <= r_pend_en;
        r_cnt  <= '0;
        r_out  <= 1'b0;
        r_busy <= 1'b0;
      end
      // An accept only happens while idle, so it never races the clears above.
      if (i_acc) begin
        r_pend_div <= i_div;
        r_pend_en  <= i_en;
        r_busy     <= 1'b1;
      end
    end
  end

  assign o_out  = r_out;
  assign o_tick = r_tick;
  assign o_busy = r_busy;

endmodule

// File: rtl/clock_divider_ctrl.sv
// Multi-channel divider controller: config handshake decode, per-channel
// accept fan-out and global sync distribution.
module clock_divider_ctrl
  import clkdiv_pkg::*;
#(
  parameter int               N_CH    = DFLT_N_CH,
  parameter int               CNT_W   = DFLT_CNT_W,
  parameter logic [CNT_W-1:0] DEF_DIV = CNT_W'(DFLT_DIV),
  parameter int               CH_W    = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  clock_divider_ctrl_if.slave  cfg,
  input  logic                 sync_i,
  output logic [N_CH-1:0]      div_out,
  output logic [N_CH-1:0]      tick_o,
  output logic [N_CH-1:0]      busy_o
);

  cfg_req_t                w_req;
  logic [(1<<CH_W)-1:0]    w_busy_ext;
  logic [N_CH-1:0]         w_acc;
  logic                    w_fire;

  assign w_req.ch  = CH_W_MAX'(cfg.cfg_ch);
  assign w_req.div = DFLT_CNT_W'(cfg.cfg_div);
  assign w_req.en  = cfg.cfg_en;

  // Unpopulated channel slots read as idle, so stray addresses are accepted and dropped.
  always_comb begin
    w_busy_ext             = '0;
    w_busy_ext[N_CH-1:0]   = busy_o;
  end

  assign cfg.cfg_ready = !w_busy_ext[cfg.cfg_ch];
  assign w_fire        = cfg.cfg_valid && cfg.cfg_ready;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    assign w_acc[i] = w_fire && (w_req.ch == CH_W_MAX'(i));

    clock_divider_channel #(
      .CNT_W   (CNT_W),
      .DEF_DIV (DEF_DIV)
    ) u_ch (
      .clk    (clk),
      .rst_n  (rst_n),
      .i_sync (sync_i),
      .i_acc  (w_acc[i]),
      .i_div  (CNT_W'(w_req.div)),
      .i_en   (w_req.en),
      .o_out  (div_out[i]),
      .o_tick (tick_o[i]),
      .o_busy (busy_o[i])
    );
  end

endmodule
